// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared sizing and the fetch-to-decode packet type
package fetch_queue_pkg;
  localparam int FQ_DEPTH = 4;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] PC;
    logic [63:0] NPC;
    logic        valid;
  } IF_ID_PACKET;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: enqueue/dequeue handshake bundle between fetch, queue and decode
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
);
  logic                   flush;
  logic                   enq_valid;
  IF_ID_PACKET            enq_packet;
  logic                   enq_ready;
  logic                   almost_full;
  logic                   deq_valid;
  IF_ID_PACKET            deq_packet;
  logic                   deq_ready;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, enq_valid, enq_packet, deq_ready,
    input  enq_ready, almost_full, deq_valid, deq_packet, count
  );
  modport slave (
    input  flush, enq_valid, enq_packet, deq_ready,
    output enq_ready, almost_full, deq_valid, deq_packet, count
  );
endinterface

// File: rtl/fetch_queue_fq_ptr.sv
// fq_ptr: wrapping pointer register with increment and synchronous clear
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_d, ptr_q;
  // clear wins over increment; wrap is the natural W-bit overflow
  always_comb ptr_d = clr ? '0 : inc ? ptr_q + W'(1) : ptr_q;
  // pointer register, async active-low reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order decoupling buffer between fetch and decode with one-cycle flush
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH     = FQ_DEPTH,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input logic        clk,
  input logic        rst,
  fetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(AFULL_LVL);
  logic [CW-1:0] count_d, count_q;
  logic [PW-1:0] head, tail;
  logic          enq_fire, deq_fire;
  IF_ID_PACKET   mem_q [DEPTH];
  // transfers only fire from registered occupancy; flush masks both sides
  always_comb begin
    enq_fire = q.enq_valid && count_q != FULL && !q.flush;
    deq_fire = q.deq_ready && count_q != '0 && !q.flush;
    count_d  = q.flush ? '0 :
               (enq_fire && !deq_fire) ? count_q + CW'(1) :
               (deq_fire && !enq_fire) ? count_q - CW'(1) : count_q;
  end
  // occupancy register, emptied immediately by reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  // storage array is left unreset; occupancy alone decides what is live
  always_ff @(posedge clk)
    if (enq_fire) mem_q[tail] <= q.enq_packet;
  fq_ptr #(.W(PW)) u_head (.clk(clk), .rst(rst), .inc(deq_fire), .clr(q.flush), .ptr(head));
  fq_ptr #(.W(PW)) u_tail (.clk(clk), .rst(rst), .inc(enq_fire), .clr(q.flush), .ptr(tail));
  // outputs depend only on registered state; empty queue presents an all-zero bubble
  always_comb begin
    q.enq_ready   = count_q != FULL;
    q.almost_full = count_q >= AFULL;
    q.deq_valid   = count_q != '0;
    q.count       = count_q;
    q.deq_packet  = '0;
    if (count_q != '0) begin
      q.deq_packet       = mem_q[head];
      q.deq_packet.valid = 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  fetch_queue_if #(.DEPTH(4)) bus ();
  fetch_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .q(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic IF_ID_PACKET mk(input logic [63:0] pc);
    IF_ID_PACKET p;
    p.inst  = 32'h1300_0000 | pc[31:0];
    p.PC    = pc;
    p.NPC   = pc + 64'd4;
    p.valid = 1'b1;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc);
    bus.enq_valid  = 1'b1;
    bus.enq_packet = mk(pc);
    step();
    bus.enq_valid  = 1'b0;
  endtask

  initial begin
    bus.flush      = 1'b0;
    bus.enq_valid  = 1'b0;
    bus.enq_packet = '0;
    bus.deq_ready  = 1'b0;
    #12;
    check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_afull", 64'(bus.almost_full), 64'd0);
    check("rst_bubble", 64'(|bus.deq_packet), 64'd0);
    rst = 1'b1;
    step();
    check("idle_count", 64'(bus.count), 64'd0);
    check("idle_bubble", 64'(|bus.deq_packet), 64'd0);

    // fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      push(64'(4 * i));
      check("fill_count", 64'(bus.count), 64'(i + 1));
      check("fill_afull", 64'(bus.almost_full), 64'(i + 1 >= 3));
      check("fill_enq_ready", 64'(bus.enq_ready), 64'(i + 1 != 4));
      check("fill_head_pc", bus.deq_packet.PC, 64'h0);
    end
    check("fill_head_inst", 64'(bus.deq_packet.inst), 64'h1300_0000);
    check("fill_head_npc", bus.deq_packet.NPC, 64'h4);

    // drain in order
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(bus.deq_valid), 64'd1);
      check("drain_pc", bus.deq_packet.PC, 64'(4 * i));
      step();
    end
    check("drain_empty_valid", 64'(bus.deq_valid), 64'd0);
    check("drain_empty_count", 64'(bus.count), 64'd0);
    check("drain_bubble", 64'(|bus.deq_packet), 64'd0);

    // streaming across pointer wrap
    bus.enq_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.enq_packet = mk(64'(4 * k));
      step();
      check("stream_count", 64'(bus.count), 64'd1);
      check("stream_pc", bus.deq_packet.PC, 64'(4 * k));
    end
    bus.enq_valid = 1'b0;
    step();
    check("stream_drained", 64'(bus.count), 64'd0);

    // full with simultaneous dequeue: enqueue refused
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'(4 * i));
    check("full_count", 64'(bus.count), 64'd4);
    bus.deq_ready  = 1'b1;
    bus.enq_valid  = 1'b1;
    bus.enq_packet = mk(64'h10);
    check("full_enq_ready", 64'(bus.enq_ready), 64'd0);
    step();
    check("full_refused_count", 64'(bus.count), 64'd3);
    check("full_refused_head", bus.deq_packet.PC, 64'h4);
    bus.deq_ready = 1'b0;
    check("full_retry_ready", 64'(bus.enq_ready), 64'd1);
    step();
    bus.enq_valid = 1'b0;
    check("full_retry_count", 64'(bus.count), 64'd4);
    bus.deq_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("full_order_pc", bus.deq_packet.PC, 64'(4 * i));
      step();
    end
    check("full_order_empty", 64'(bus.count), 64'd0);

    // flush beats same-cycle enqueue and dequeue
    bus.deq_ready = 1'b0;
    push(64'h20);
    push(64'h24);
    push(64'h28);
    check("flush_pre_count", 64'(bus.count), 64'd3);
    bus.flush      = 1'b1;
    bus.enq_valid  = 1'b1;
    bus.enq_packet = mk(64'h40);
    bus.deq_ready  = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("flush_bubble", 64'(|bus.deq_packet), 64'd0);
    push(64'h80);
    check("post_flush_count", 64'(bus.count), 64'd1);
    check("post_flush_pc", bus.deq_packet.PC, 64'h80);
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    check("post_flush_empty", 64'(bus.count), 64'd0);

    // asynchronous reset mid-stream
    push(64'h50);
    push(64'h54);
    push(64'h58);
    check("arst_pre_count", 64'(bus.count), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("arst_enq_ready", 64'(bus.enq_ready), 64'd1);
    rst = 1'b1;
    push(64'h100);
    check("arst_first_count", 64'(bus.count), 64'd1);
    check("arst_first_pc", bus.deq_packet.PC, 64'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
